// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the multi-channel one-shot pulse generator.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_t;

  localparam int DEFAULT_LEN_C = 5;

  // Event from the synchronised level s and its one-cycle-old copy p.
  function automatic logic edge_event(input edge_mode_t mode, input logic s, input logic p);
    logic ev;
    ev = 1'b0;
    case (mode)
      EDGE_RISE: ev = s & ~p;
      EDGE_FALL: ev = ~s & p;
      EDGE_BOTH: ev = s ^ p;
      default:   ev = 1'b0;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/pulse_channel.sv
// One channel: input synchroniser, edge detect, config registers,
// pulse-length counter and sticky overrun flag.
module pulse_channel
  import pulse_gen_pkg::*;
#(
  parameter int LEN_W       = 16,
  parameter int DEFAULT_LEN = DEFAULT_LEN_C,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             we,
  input  logic [LEN_W-1:0] wr_len,
  input  logic [1:0]       wr_mode,
  input  logic             wr_retrig,
  input  logic             ovr_clr,
  output logic             out,
  output logic             overrun
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   p;
  logic [LEN_W-1:0]       len;
  logic [LEN_W-1:0]       cnt;
  edge_mode_t             mode;
  logic                   retrig;
  logic                   ev;
  logic                   load;
  logic                   ignore;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      p      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      p      <= s;
    end
  end

  // Events see the config registered before this edge, so a write in the
  // same cycle only affects later triggers.
  assign ev     = edge_event(mode, s, p);
  assign load   = ev && (len != '0) && ((cnt == '0) || retrig);
  assign ignore = ev && (len != '0) && (cnt != '0) && !retrig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len    <= LEN_W'(DEFAULT_LEN);
      mode   <= EDGE_RISE;
      retrig <= 1'b0;
    end else if (we) begin
      len    <= wr_len;
      mode   <= edge_mode_t'(wr_mode);
      retrig <= wr_retrig;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (load) begin
      cnt <= len;
      out <= 1'b1;
    end else if (cnt > LEN_W'(1)) begin
      cnt <= cnt - LEN_W'(1);
    end else if (cnt == LEN_W'(1)) begin
      cnt <= '0;
      out <= 1'b0;
    end
  end

  // Set has priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (ignore) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_channel_pulse_gen.sv
// CH independent edge-triggered one-shots with per-channel length, edge mode,
// retrigger enable and overrun flag; config written one channel at a time.
module multi_channel_pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int  CH          = 4,
  parameter int  LEN_W       = 16,
  parameter int  DEFAULT_LEN = DEFAULT_LEN_C,
  parameter int  SYNC_STAGES = 2,
  localparam int CH_W        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    in,
  input  logic             wr,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [LEN_W-1:0] wr_len,
  input  logic [1:0]       wr_mode,
  input  logic             wr_retrig,
  input  logic [CH-1:0]    ovr_clr,
  output logic [CH-1:0]    out,
  output logic [CH-1:0]    busy,
  output logic [CH-1:0]    overrun
);

  logic          wr_ok;
  logic [CH-1:0] we;

  // Indices at or beyond CH are dropped rather than aliased onto a channel.
  assign wr_ok = wr && (int'(wr_ch) < CH);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign we[i] = wr_ok && (wr_ch == CH_W'(i));

    pulse_channel #(
      .LEN_W       (LEN_W),
      .DEFAULT_LEN (DEFAULT_LEN),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .in        (in[i]),
      .we        (we[i]),
      .wr_len    (wr_len),
      .wr_mode   (wr_mode),
      .wr_retrig (wr_retrig),
      .ovr_clr   (ovr_clr[i]),
      .out       (out[i]),
      .overrun   (overrun[i])
    );
  end

  assign busy = out;

endmodule

// File: tb/tb_multi_channel_pulse_gen.sv
// Bench for multi_channel_pulse_gen: cycle model compared every cycle, plus
// literal pulse-width and latency expectations from directed scenarios.
module tb_multi_channel_pulse_gen;

  localparam int CH    = 5;
  localparam int LEN_W = 16;
  localparam int SS    = 2;
  localparam int CW    = 3;

  logic             clk;
  logic             rst;
  logic [CH-1:0]    in_sig;
  logic             wr;
  logic [CW-1:0]    wr_ch;
  logic [LEN_W-1:0] wr_len;
  logic [1:0]       wr_mode;
  logic             wr_retrig;
  logic [CH-1:0]    ovr_clr;
  logic [CH-1:0]    out;
  logic [CH-1:0]    busy;
  logic [CH-1:0]    overrun;

  int n_checks = 0;
  int n_errors = 0;

  multi_channel_pulse_gen #(
    .CH          (CH),
    .LEN_W       (LEN_W),
    .DEFAULT_LEN (5),
    .SYNC_STAGES (SS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_sig),
    .wr        (wr),
    .wr_ch     (wr_ch),
    .wr_len    (wr_len),
    .wr_mode   (wr_mode),
    .wr_retrig (wr_retrig),
    .ovr_clr   (ovr_clr),
    .out       (out),
    .busy      (busy),
    .overrun   (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // model: a pulse on channel c is high after edge k while k < end_k[c]
  int               k;
  int               end_k   [CH];
  int               m_len   [CH];
  int               m_mode  [CH];
  bit               m_retrig[CH];
  bit               m_ovr   [CH];
  logic [CH-1:0]    hist_q[$];
  logic [CH-1:0]    sv, pv, exp_out, exp_ovr;
  bit               evt, was_busy, set_ovr, model_live;

  task automatic model_reset();
    k = 0;
    for (int c = 0; c < CH; c++) begin
      end_k[c] = -1; m_len[c] = 5; m_mode[c] = 0; m_retrig[c] = 1'b0; m_ovr[c] = 1'b0;
    end
    hist_q.delete();
    for (int j = 0; j <= SS; j++) hist_q.push_back('0);
    exp_out = '0;
    exp_ovr = '0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
      model_live = 1'b1;
    end else if (model_live) begin
      sv = hist_q[SS-1];
      pv = hist_q[SS];
      for (int c = 0; c < CH; c++) begin
        case (m_mode[c])
          0: evt = sv[c] & ~pv[c];
          1: evt = ~sv[c] & pv[c];
          2: evt = sv[c] ^ pv[c];
          default: evt = 1'b0;
        endcase
        was_busy = (k - 1) < end_k[c];
        set_ovr = 1'b0;
        if (evt && m_len[c] != 0) begin
          if (!was_busy || m_retrig[c]) end_k[c] = k + m_len[c];
          else set_ovr = 1'b1;
        end
        m_ovr[c] = set_ovr ? 1'b1 : (ovr_clr[c] ? 1'b0 : m_ovr[c]);
        exp_out[c] = k < end_k[c];
        exp_ovr[c] = m_ovr[c];
      end
      if (wr && int'(wr_ch) < CH) begin
        m_len[wr_ch] = int'(wr_len);
        m_mode[wr_ch] = int'(wr_mode);
        m_retrig[wr_ch] = wr_retrig;
      end
      hist_q.push_front(in_sig);
      void'(hist_q.pop_back());
      k++;
    end
    #1;
    if (!rst && model_live) begin
      n_checks++;
      if ({out, busy, overrun} !== {exp_out, exp_out, exp_ovr}) begin
        n_errors++;
        $display("FAIL cycle_model t=%0t: out=%b busy=%b overrun=%b required out=%b busy=%b overrun=%b",
                 $time, out, busy, overrun, exp_out, exp_out, exp_ovr);
      end
    end
  end

  // pulse-width monitor feeding the scoreboard queue with {channel, width}
  logic [31:0] exp_q[$];
  int          run[CH];

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < CH; c++) begin
      if (rst) run[c] = 0;
      else if (out[c]) run[c]++;
      else if (run[c] > 0) begin
        exp_q.push_back((c << 16) | run[c]);
        run[c] = 0;
      end
    end
  end

  // driver tasks
  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic expect_pulse(input string name, input int ch, input int width);
    logic [31:0] v;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: no pulse seen, required ch%0d width %0d", name, ch, width);
    end else begin
      v = exp_q.pop_front();
      if (v !== ((ch << 16) | width)) begin
        n_errors++;
        $display("FAIL %s: got ch%0d width %0d required ch%0d width %0d",
                 name, v[31:16], v[15:0], ch, width);
      end
    end
  endtask

  task automatic expect_none(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic cfg_write(input int ch, input int len, input int mode, input bit retrig);
    @(negedge clk);
    wr = 1'b1; wr_ch = ch[CW-1:0]; wr_len = len[LEN_W-1:0]; wr_mode = mode[1:0]; wr_retrig = retrig;
    @(negedge clk);
    wr = 1'b0;
  endtask

  // Rise, dip, rise again so the second event lands at edge 6 (pulse cycle 5,
  // after 4 elapsed cycles); optionally clear overrun in that same cycle.
  task automatic retrig_seq(input int ch, input bit clr);
    @(negedge clk);
    in_sig[ch] = 1'b1;
    repeat (3) @(negedge clk);
    in_sig[ch] = 1'b0;
    @(negedge clk);
    in_sig[ch] = 1'b1;
    repeat (2) @(negedge clk);
    if (clr) ovr_clr[ch] = 1'b1;
    @(negedge clk);
    ovr_clr = '0;
    repeat (14) @(negedge clk);
    in_sig[ch] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_sig = '0; wr = 1'b0; wr_ch = '0; wr_len = '0;
    wr_mode = '0; wr_retrig = 1'b0; ovr_clr = '0; model_live = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", int'(out), 0);
    check("reset_overrun", int'(overrun), 0);
    rst = 1'b0;

    // 1: default 5-cycle pulse, 2-edge latency
    @(negedge clk);
    in_sig[0] = 1'b1;
    @(posedge clk); #1 check("s1_edge0_low", int'(out[0]), 0);
    @(posedge clk); #1 check("s1_edge1_low", int'(out[0]), 0);
    @(posedge clk); #1 check("s1_edge2_high", int'(out[0]), 1);
    repeat (8) @(negedge clk);
    expect_pulse("s1_width", 0, 5);
    expect_none("s1_other_channels");
    in_sig[0] = 1'b0;
    repeat (4) @(negedge clk);

    // 2: falling-edge mode, length 3
    cfg_write(1, 3, 1, 1'b0);
    in_sig[1] = 1'b1;
    repeat (6) @(negedge clk);
    expect_none("s2_no_rise_pulse");
    in_sig[1] = 1'b0;
    repeat (8) @(negedge clk);
    expect_pulse("s2_fall_width", 1, 3);

    // 3: retrigger extends to 4 + 10
    cfg_write(2, 10, 0, 1'b1);
    retrig_seq(2, 1'b0);
    expect_pulse("s3_retrig_width", 2, 14);
    expect_none("s3_single_pulse");
    check("s3_no_overrun", int'(overrun[2]), 0);

    // 4: no retrigger -> ignored edge, sticky overrun, set beats clear
    cfg_write(2, 10, 0, 1'b0);
    retrig_seq(2, 1'b0);
    expect_pulse("s4_width", 2, 10);
    check("s4_overrun_set", int'(overrun[2]), 1);
    repeat (3) @(negedge clk);
    check("s4_overrun_sticky", int'(overrun[2]), 1);
    ovr_clr[2] = 1'b1;
    @(negedge clk);
    ovr_clr = '0;
    check("s4_overrun_cleared", int'(overrun[2]), 0);
    retrig_seq(2, 1'b1);
    expect_pulse("s4_width_again", 2, 10);
    check("s4_set_beats_clear", int'(overrun[2]), 1);

    // 5: zero length, out-of-range writes, length change mid-pulse
    cfg_write(3, 0, 0, 1'b0);
    in_sig[3] = 1'b1;
    repeat (6) @(negedge clk);
    in_sig[3] = 1'b0;
    repeat (6) @(negedge clk);
    expect_none("s5_len0_no_pulse");
    check("s5_len0_no_overrun", int'(overrun[3]), 0);
    cfg_write(5, 2, 0, 1'b1);
    cfg_write(7, 2, 3, 1'b1);
    in_sig[4] = 1'b1;
    repeat (8) @(negedge clk);
    expect_pulse("s5_ch4_default", 4, 5);
    in_sig[4] = 1'b0;
    in_sig[1] = 1'b1;
    repeat (6) @(negedge clk);
    expect_none("s5_ch1_still_fall");
    in_sig[1] = 1'b0;
    repeat (6) @(negedge clk);
    expect_pulse("s5_ch1_still_len3", 1, 3);
    in_sig[0] = 1'b1;
    repeat (3) @(negedge clk);
    cfg_write(0, 8, 0, 1'b0);
    repeat (6) @(negedge clk);
    expect_pulse("s5_running_keeps_len", 0, 5);
    in_sig[0] = 1'b0;
    repeat (3) @(negedge clk);
    in_sig[0] = 1'b1;
    repeat (12) @(negedge clk);
    expect_pulse("s5_next_uses_len8", 0, 8);
    in_sig[0] = 1'b0;
    repeat (3) @(negedge clk);

    // 6: reset mid-pulse, defaults restored
    in_sig[4] = 1'b1;
    repeat (4) @(negedge clk);
    check("s6_pre_reset_high", int'(out[4]), 1);
    rst = 1'b1;
    #1;
    check("s6_async_out", int'(out), 0);
    check("s6_async_busy", int'(busy), 0);
    check("s6_async_overrun", int'(overrun), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    expect_pulse("s6_held_high_event", 4, 5);
    in_sig[4] = 1'b0;
    in_sig[0] = 1'b1;
    repeat (10) @(negedge clk);
    expect_pulse("s6_ch0_len_default", 0, 5);
    in_sig[0] = 1'b0;
    in_sig[1] = 1'b1;
    repeat (10) @(negedge clk);
    expect_pulse("s6_ch1_mode_rise", 1, 5);
    in_sig[1] = 1'b0;
    repeat (6) @(negedge clk);
    expect_none("s6_no_fall_pulse");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
